// File: rtl/lcd_char_arbiter.sv
// lcd_char_arbiter
// Round-robin arbiter that funnels character-draw requests from NUM_CH
// display producers onto the single lcd_show_char engine.
//
// Handshake: channel i's request is taken on a rising sys_clk edge where
// req_valid[i] and req_ready[i] are both high. req_ready is only ever
// asserted in IDLE with init_done=1, one-hot on the round-robin winner among
// the enabled, valid channels. A request may be held or withdrawn freely
// while ready is low.
//
// Ports:
//   sys_clk, sys_rst       clock, asynchronous active-high reset
//   init_done              LCD init complete; low blocks and aborts issue
//   ch_enable[NUM_CH]      per-channel enable mask
//   req_valid/req_ready    per-channel handshake
//   req_ascii/x/y/size/bg/fg  packed per-channel character fields
//   show_char_done         one-cycle completion from lcd_show_char
//   show_char_flag         one-cycle start pulse to lcd_show_char
//   ascii_num..front_color latched fields of the granted request
//   grant_id               channel of the current/last transaction
//   busy                   high while in ISSUE or WAIT
//   char_done              one-cycle pulse on a completed character
//   timeout_err            one-cycle pulse on watchdog expiry
//   state_dbg              current FSM state (0=IDLE, 1=ISSUE, 2=WAIT)
module lcd_char_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int TIMEOUT_CYC = 200000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 init_done,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic [NUM_CH-1:0]    req_valid,
  output logic [NUM_CH-1:0]    req_ready,
  input  logic [8*NUM_CH-1:0]  req_ascii,
  input  logic [9*NUM_CH-1:0]  req_x,
  input  logic [9*NUM_CH-1:0]  req_y,
  input  logic [NUM_CH-1:0]    req_size,
  input  logic [16*NUM_CH-1:0] req_bg,
  input  logic [16*NUM_CH-1:0] req_fg,
  input  logic                 show_char_done,
  output logic                 show_char_flag,
  output logic [7:0]           ascii_num,
  output logic [8:0]           start_x,
  output logic [8:0]           start_y,
  output logic                 en_size,
  output logic [15:0]          background_color,
  output logic [15:0]          front_color,
  output logic [CH_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 char_done,
  output logic                 timeout_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [31:0]       timer;

  logic [NUM_CH-1:0] elig;
  logic              win_found;
  logic [CH_W-1:0]   win_idx;
  logic              accept;
  logic [CH_W-1:0]   next_ptr;
  logic              timer_expired;

  assign elig = req_valid & ch_enable;

  // Search starts at rr_ptr and wraps; the first eligible channel wins.
  always_comb begin
    int idx;
    logic [CH_W-1:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = CH_W'(idx);
      if (!win_found && elig[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  assign accept = (state == IDLE) && init_done && win_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  // With NUM_CH=1 grant_id is always 0, so this collapses to a constant 0.
  assign next_ptr = (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;

  assign timer_expired = (TIMEOUT_CYC != 0) && (timer == 32'(TIMEOUT_CYC - 1));

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      timer            <= '0;
      show_char_flag   <= 1'b0;
      ascii_num        <= '0;
      start_x          <= '0;
      start_y          <= '0;
      en_size          <= 1'b0;
      background_color <= '0;
      front_color      <= '0;
      grant_id         <= '0;
      char_done        <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      show_char_flag <= 1'b0;
      char_done      <= 1'b0;
      timeout_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ascii_num        <= req_ascii[32'(win_idx)*8 +: 8];
            start_x          <= req_x[32'(win_idx)*9 +: 9];
            start_y          <= req_y[32'(win_idx)*9 +: 9];
            en_size          <= req_size[win_idx];
            background_color <= req_bg[32'(win_idx)*16 +: 16];
            front_color      <= req_fg[32'(win_idx)*16 +: 16];
            grant_id         <= win_idx;
            show_char_flag   <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= init_done ? WAIT : IDLE;
        end
        WAIT: begin
          // A reinit abort leaves rr_ptr alone so the same channel goes first.
          if (!init_done) begin
            state <= IDLE;
          end else if (show_char_done) begin
            char_done <= 1'b1;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end else if (timer != 32'hFFFF_FFFF) begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
